spi_master_ctrl: RTL and testbench

//  Sequencer for the SPI byte engine behind wishbone_if. Takes the one-hot request strobes
//  (cmd/wr/rd) and 11-bit write data from the bus interface, holds the SPI configuration,

---
 rtl/spi_master_ctrl.sv | 210 +++++++++++++++++++++
 tb/tb_spi_master_ctrl.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master_ctrl.sv
// SPI byte sequencer: holds config, runs one 8-bit full-duplex transfer per write, returns {rx_valid, rx_byte}.
// Latency: cmd/rd ack one cycle after the request edge; a write is acked 16*(DIV+1)+1 cycles after its edge.
// Backpressure: none. Requests are edge-triggered, and a cmd arriving mid-byte is held until the byte completes.
module spi_master_ctrl #(
    parameter logic [7:0] DIV_RST  = 8'd4,
    parameter logic       CPOL_RST = 1'b0,
    parameter logic       CPHA_RST = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [10:0] req_data,
    input  logic        req_cmd,
    input  logic        req_wr,
    input  logic        req_rd,
    output logic [8:0]  rsp_data,
    output logic        rsp_ack,
    output logic        sclk,
    output logic        mosi,
    input  logic        miso,
    output logic        ss_n
);

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

    state_t      r_state;
    state_t      w_next;
    logic [7:0]  r_div;
    logic        r_cpol;
    logic        r_cpha;
    logic        r_ss;
    logic        r_sclk;
    logic [7:0]  r_tx;
    logic [7:0]  r_rx;
    logic [7:0]  r_rx_byte;
    logic        r_rx_valid;
    logic [8:0]  r_rsp_data;
    logic        r_ack;
    logic [7:0]  r_cnt;
    logic [3:0]  r_edge;
    logic        r_cmd_d;
    logic        r_wr_d;
    logic        r_rd_d;
    logic        r_cmd_pend;
    logic [10:0] r_cmd_data;
    logic        r_miso_s1;
    logic        r_miso_s2;

    logic        w_cmd_edge;
    logic        w_wr_edge;
    logic        w_rd_edge;
    logic        w_tick;
    logic        w_sample;
    logic        w_shift;
    logic [10:0] w_cfg_src;
    logic        w_do_cfg;
    logic        w_do_rd;
    logic        w_start;
    logic        w_done;
    logic        w_pend_set;

    assign w_cmd_edge = req_cmd & ~r_cmd_d;
    assign w_wr_edge  = req_wr  & ~r_wr_d;
    assign w_rd_edge  = req_rd  & ~r_rd_d;

    // r_edge holds the number of SCLK edges already produced, so edge number = r_edge + 1
    assign w_tick   = (r_state == S_SHIFT) && (r_cnt == r_div);
    assign w_sample = w_tick && (r_cpha ? r_edge[0] : ~r_edge[0]);
    assign w_shift  = w_tick && (r_cpha ? (~r_edge[0] && (r_edge >= 4'd2))
                                        : ( r_edge[0] && (r_edge <= 4'd13)));

    // A cmd deferred from mid-byte is applied from its captured copy
    assign w_cfg_src = r_cmd_pend ? r_cmd_data : req_data;

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state and per-cycle action strobes
    always_comb begin
        w_next     = r_state;
        w_do_cfg   = 1'b0;
        w_do_rd    = 1'b0;
        w_start    = 1'b0;
        w_done     = 1'b0;
        w_pend_set = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_cmd_pend || w_cmd_edge) begin
                    w_do_cfg = 1'b1;
                end else if (w_wr_edge) begin
                    w_start = 1'b1;
                    w_next  = S_SHIFT;
                end else if (w_rd_edge) begin
                    w_do_rd = 1'b1;
                end
            end
            S_SHIFT: begin
                if (w_tick && (r_edge == 4'd15)) begin
                    w_next = S_DONE;
                end
                if (w_cmd_edge) begin
                    w_pend_set = 1'b1;
                end else if (w_rd_edge) begin
                    w_do_rd = 1'b1;
                end
            end
            S_DONE: begin
                w_next = S_IDLE;
                w_done = 1'b1;
                if (w_cmd_edge) begin
                    w_pend_set = 1'b1;
                end else if (w_rd_edge) begin
                    w_do_rd = 1'b1;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Datapath: request edge detect, miso sync, config, shifting, response
    always_ff @(posedge clk) begin
        if (!rst) begin
            // Edge detectors start high so a request level held through reset is not replayed
            r_cmd_d    <= 1'b1;
            r_wr_d     <= 1'b1;
            r_rd_d     <= 1'b1;
            r_miso_s1  <= 1'b0;
            r_miso_s2  <= 1'b0;
            r_div      <= DIV_RST;
            r_cpol     <= CPOL_RST;
            r_cpha     <= CPHA_RST;
            r_ss       <= 1'b0;
            r_sclk     <= CPOL_RST;
            r_tx       <= 8'h00;
            r_rx       <= 8'h00;
            r_rx_byte  <= 8'h00;
            r_rx_valid <= 1'b0;
            r_rsp_data <= 9'h000;
            r_ack      <= 1'b0;
            r_cnt      <= 8'h00;
            r_edge     <= 4'h0;
            r_cmd_pend <= 1'b0;
            r_cmd_data <= 11'h000;
        end else begin
            r_cmd_d   <= req_cmd;
            r_wr_d    <= req_wr;
            r_rd_d    <= req_rd;
            r_miso_s1 <= miso;
            r_miso_s2 <= r_miso_s1;
            r_ack     <= w_do_cfg | w_do_rd | w_done;

            if (w_do_cfg) begin
                r_div      <= w_cfg_src[7:0];
                r_cpol     <= w_cfg_src[8];
                r_cpha     <= w_cfg_src[9];
                r_ss       <= w_cfg_src[10];
                r_sclk     <= w_cfg_src[8];
                r_cmd_pend <= 1'b0;
            end
            if (w_pend_set) begin
                r_cmd_pend <= 1'b1;
                r_cmd_data <= req_data;
            end

            if (w_start) begin
                r_tx   <= req_data[7:0];
                r_rx   <= 8'h00;
                r_cnt  <= 8'h00;
                r_edge <= 4'h0;
            end else if (r_state == S_SHIFT) begin
                if (w_tick) begin
                    r_cnt  <= 8'h00;
                    r_sclk <= ~r_sclk;
                    r_edge <= r_edge + 4'd1;
                end else begin
                    r_cnt <= r_cnt + 8'd1;
                end
                if (w_sample) begin
                    r_rx <= {r_rx[6:0], r_miso_s2};
                end
                if (w_shift) begin
                    r_tx <= {r_tx[6:0], 1'b0};
                end
            end

            // A read coinciding with DONE returns the old byte; DONE's set of rx_valid wins
            if (w_do_rd) begin
                r_rsp_data <= {r_rx_valid, r_rx_byte};
            end
            if (w_done) begin
                r_rx_byte  <= r_rx;
                r_rx_valid <= 1'b1;
            end else if (w_do_rd) begin
                r_rx_valid <= 1'b0;
            end
        end
    end

    assign rsp_data = r_rsp_data;
    assign rsp_ack  = r_ack;
    assign sclk     = r_sclk;
    assign mosi     = r_tx[7];
    assign ss_n     = ~r_ss;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Self-checking bench for spi_master_ctrl: directed steps plus randomized transfers against a behavioural model.
// Model tracks config and rx register; transfer timing and bit order are derived from SCLK edge arithmetic.
// A slave model drives miso ahead of each sample edge, allowing for the DUT's two-flop input synchroniser.
module tb_spi_master_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [10:0] req_data;
    logic        req_cmd;
    logic        req_wr;
    logic        req_rd;
    logic [8:0]  rsp_data;
    logic        rsp_ack;
    logic        sclk;
    logic        mosi;
    logic        miso;
    logic        ss_n;

    int n_cmp = 0;
    int n_bad = 0;

    // Behavioural model state
    int         m_div;
    bit         m_cpol;
    bit         m_cpha;
    bit         m_ss;
    logic [7:0] m_rxb;
    bit         m_rxv;

    always #5 clk = ~clk;

    spi_master_ctrl #(
        .DIV_RST  (8'd4),
        .CPOL_RST (1'b0),
        .CPHA_RST (1'b0)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req_data (req_data),
        .req_cmd  (req_cmd),
        .req_wr   (req_wr),
        .req_rd   (req_rd),
        .rsp_data (rsp_data),
        .rsp_ack  (rsp_ack),
        .sclk     (sclk),
        .mosi     (mosi),
        .miso     (miso),
        .ss_n     (ss_n)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Bit the slave presents when miso is set in the cycle after posedge P0+n: it reaches the
    // sampler three posedges later, so present the bit of the first sample edge at or beyond that.
    function automatic logic slave_bit(input int n, input int d, input bit cpha, input logic [7:0] b);
        int e;
        for (int j = 0; j < 8; j++) begin
            e = cpha ? (2 * j + 2) : (2 * j + 1);
            if (e * (d + 1) >= n + 3) return b[7 - j];
        end
        return 1'b0;
    endfunction

    task automatic do_cmd(input logic [10:0] d);
        req_data = d;
        req_cmd  = 1'b1;
        tick();
        chk("cmd_ack", rsp_ack, 1);
        m_div  = int'(d[7:0]);
        m_cpol = d[8];
        m_cpha = d[9];
        m_ss   = d[10];
        chk("cmd_sclk_idle", sclk, m_cpol);
        chk("cmd_ss_n", ss_n, !m_ss);
        req_cmd = 1'b0;
        tick();
        chk("cmd_ack_pulse", rsp_ack, 0);
    endtask

    task automatic do_rd(input int hold);
        logic [8:0] exp;
        exp    = {m_rxv, m_rxb};
        req_rd = 1'b1;
        tick();
        chk("rd_ack", rsp_ack, 1);
        chk("rd_data", rsp_data, exp);
        m_rxv = 1'b0;
        for (int i = 1; i < hold; i++) begin
            tick();
            chk("rd_ack_once", rsp_ack, 0);
        end
        req_rd = 1'b0;
        tick();
        chk("rd_ack_low", rsp_ack, 0);
        chk("rd_data_hold", rsp_data, exp);
    endtask

    // One write transfer; optional read edge (rd_at) and cmd edge (cmd_at) raised at cycle offsets after the wr edge
    task automatic do_xfer(input logic [7:0] tx, input logic [7:0] sb, input bit loopb,
                           input int rd_at, input int cmd_at, input logic [10:0] cmd_dat);
        int         a;
        int         toggles;
        logic       prev;
        logic [7:0] exp_rx;
        bit         exp_ack;
        a       = 16 * (m_div + 1) + 1;
        toggles = 0;
        prev    = sclk;
        exp_rx  = loopb ? tx : sb;
        req_data = {3'b000, tx};
        req_wr   = 1'b1;
        miso     = loopb ? mosi : slave_bit(-1, m_div, m_cpha, sb);
        for (int o = 0; o <= a + 1; o++) begin
            tick();
            exp_ack = (o == a) || (rd_at >= 0 && o == rd_at + 1) || (cmd_at >= 0 && o == a + 1);
            chk("xfer_ack", rsp_ack, exp_ack);
            if (rd_at >= 0 && o == rd_at + 1) begin
                chk("xfer_rd_data", rsp_data, {m_rxv, m_rxb});
                m_rxv  = 1'b0;
                req_rd = 1'b0;
            end
            if (o < a && sclk !== prev) begin
                toggles++;
                chk("sclk_edge_time", o, toggles * (m_div + 1));
                prev = sclk;
            end
            for (int j = 0; j < 8; j++) begin
                if (o + 1 == (m_cpha ? (2 * j + 2) : (2 * j + 1)) * (m_div + 1))
                    chk("mosi_bit", mosi, tx[7 - j]);
            end
            if (o == a) begin
                chk("sclk_edge_count", toggles, 16);
                chk("sclk_end_idle", sclk, m_cpol);
                m_rxb  = exp_rx;
                m_rxv  = 1'b1;
                req_wr = 1'b0;
            end
            if (cmd_at >= 0 && o == a + 1) begin
                chk("pend_cmd_sclk", sclk, cmd_dat[8]);
                chk("pend_cmd_ss_n", ss_n, !cmd_dat[10]);
                m_div   = int'(cmd_dat[7:0]);
                m_cpol  = cmd_dat[8];
                m_cpha  = cmd_dat[9];
                m_ss    = cmd_dat[10];
                req_cmd = 1'b0;
            end
            if (o == cmd_at) begin
                req_data = cmd_dat;
                req_cmd  = 1'b1;
            end
            if (o == rd_at) req_rd = 1'b1;
            miso = loopb ? mosi : slave_bit(o, m_div, m_cpha, sb);
        end
        tick();
        chk("xfer_ack_after", rsp_ack, 0);
    endtask

    initial begin
        int         acks;
        int         ra;
        int         ca;
        logic [10:0] c;

        rst      = 1'b0;
        req_data = 11'h000;
        req_cmd  = 1'b0;
        req_wr   = 1'b0;
        req_rd   = 1'b0;
        miso     = 1'b0;
        repeat (3) tick();
        chk("rst_sclk", sclk, 0);
        chk("rst_ss_n", ss_n, 1);
        chk("rst_mosi", mosi, 0);
        chk("rst_ack", rsp_ack, 0);
        chk("rst_rsp_data", rsp_data, 0);
        rst = 1'b1;
        tick();
        m_div = 4; m_cpol = 1'b0; m_cpha = 1'b0; m_ss = 1'b0; m_rxb = 8'h00; m_rxv = 1'b0;

        // Transfer with reset-default configuration
        do_xfer(8'($urandom), 8'($urandom), 1'b0, -1, -1, 11'h000);
        do_rd(1);

        // Reset mid-transfer: no completion ack afterwards, outputs back to reset values
        do_cmd(11'h503);
        req_data = 11'h05A;
        req_wr   = 1'b1;
        repeat (20) tick();
        req_wr = 1'b0;
        rst    = 1'b0;
        repeat (3) tick();
        chk("midrst_sclk", sclk, 0);
        chk("midrst_ss_n", ss_n, 1);
        chk("midrst_ack", rsp_ack, 0);
        chk("midrst_rsp_data", rsp_data, 0);
        rst = 1'b1;
        m_div = 4; m_cpol = 1'b0; m_cpha = 1'b0; m_ss = 1'b0; m_rxb = 8'h00; m_rxv = 1'b0;
        acks = 0;
        repeat (100) begin
            tick();
            if (rsp_ack) acks++;
        end
        chk("midrst_no_ack", acks, 0);
        chk("midrst_sclk_quiet", sclk, 0);
        do_rd(1);

        // DIV=2, SS=1, mode 0, miso looped back from mosi
        do_cmd(11'h402);
        do_xfer(8'hA5, 8'h00, 1'b1, -1, -1, 11'h000);
        do_rd(1);
        do_rd(1);

        // CPOL=1, CPHA=1, DIV=0, slave returns 8'hC3
        do_cmd(11'h700);
        do_xfer(8'h3C, 8'hC3, 1'b0, -1, -1, 11'h000);
        do_rd(1);

        // Read level held four cycles; cmd edge raised mid-byte
        do_rd(4);
        do_cmd(11'h401);
        do_xfer(8'($urandom), 8'($urandom), 1'b0, -1, 7, 11'h702);
        do_rd(1);

        // Read edge coinciding with DONE
        do_xfer(8'($urandom), 8'($urandom), 1'b0, 16 * (m_div + 1), -1, 11'h000);
        do_rd(1);

        // Randomized configurations with optional mid-byte read or cmd
        for (int it = 0; it < 6; it++) begin
            c = {1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom_range(0, 3))};
            do_cmd(c);
            ra = -1;
            ca = -1;
            if (it % 3 == 1) ra = int'($urandom_range(0, 16 * (m_div + 1) - 1));
            else if (it % 3 == 2) ca = int'($urandom_range(0, 16 * (m_div + 1) - 1));
            do_xfer(8'($urandom), 8'($urandom), 1'b0, ra, ca,
                    {1'b1, 2'($urandom_range(0, 3)), 8'($urandom_range(0, 2))});
            do_rd(1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
